// File: rtl/final_cpa_pipe.sv
// Two-stage final carry-propagate adder for a compressor tree: the low half is
// added in stage 1, the high half plus the mid carry in stage 2, with a
// valid/ready handshake on both sides.
module final_cpa_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic            s1_valid;
    logic [LO_W-1:0] lo_sum;
    logic            c_mid;
    logic [HI_W-1:0] hi_s;
    logic [HI_W-1:0] hi_c;

    logic            s1_load;
    logic            s2_load;
    logic            s2_free;
    logic [LO_W:0]   lo_add;
    logic [HI_W-1:0] hi_add;

    // Stage 2 can take new data when empty or when its product leaves this cycle.
    assign s2_free  = !out_valid || out_ready;
    assign s2_load  = s1_valid && s2_free;
    assign in_ready = !rst && (!s1_valid || s2_free);
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        lo_add = {1'b0, sum_vec[LO_W-1:0]} + {1'b0, carry_vec[LO_W-1:0]};
        hi_add = hi_s + hi_c + {{(HI_W-1){1'b0}}, c_mid};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            lo_sum   <= '0;
            c_mid    <= 1'b0;
            hi_s     <= '0;
            hi_c     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            lo_sum   <= lo_add[LO_W-1:0];
            c_mid    <= lo_add[LO_W];
            hi_s     <= sum_vec[WIDTH-1:LO_W];
            hi_c     <= carry_vec[WIDTH-1:LO_W];
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            product   <= {hi_add, lo_sum};
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_final_cpa_pipe.sv
// Bench for final_cpa_pipe: directed latency/wrap/backpressure/reset cases plus
// a randomized handshake run scored against a queue of (s+c) mod 2^32.
module tb_final_cpa_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] sum_vec = '0;
    logic [W-1:0] carry_vec = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] product;

    int unsigned  total = 0;
    int unsigned  bad = 0;
    int unsigned  accepted = 0;
    logic [W-1:0] expq[$];

    final_cpa_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] c);
        in_valid  = v;
        sum_vec   = s;
        carry_vec = c;
    endtask

    // Scoreboard and hold monitor, evaluated at the negedge for the coming posedge.
    logic         hold_prev = 1'b0;
    logic [W-1:0] prod_prev = '0;
    always @(negedge clk) begin
        if (hold_prev && !rst) begin
            check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
            check_eq("hold_product", {32'd0, product}, {32'd0, prod_prev});
        end
        if (rst) begin
            expq.delete();
            hold_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0)
                    check_eq("sb_extra_output", 64'd1, 64'd0);
                else
                    check_eq("sb_product", {32'd0, product}, {32'd0, expq.pop_front()});
            end
            if (in_valid && in_ready) begin
                expq.push_back(sum_vec + carry_vec);
                accepted++;
            end
            hold_prev = out_valid && !out_ready;
            prod_prev = product;
        end
    end

    logic [W-1:0] ss[8];
    logic [W-1:0] cs[8];

    initial begin
        // Reset state
        tick();
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_product", {32'd0, product}, 64'd0);
        check_eq("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Latency with mid carry crossing the halves: launched after edge N
        out_ready = 1'b1;
        drive(1'b1, 32'h0000FFFF, 32'h00000001);
        tick();
        drive(1'b0, '0, '0);
        check_eq("lat_n1_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check_eq("lat_n2_valid", {63'd0, out_valid}, 64'd1);
        check_eq("lat_mid_carry", {32'd0, product}, 64'h00010000);
        tick();
        check_eq("lat_drained", {63'd0, out_valid}, 64'd0);

        // Wrap and second directed vector
        drive(1'b1, 32'hFFFFFFFF, 32'h00000001);
        tick();
        drive(1'b1, 32'h12345678, 32'h0000A988);
        tick();
        drive(1'b0, '0, '0);
        check_eq("wrap", {32'd0, product}, 64'h0);
        check_eq("wrap_valid", {63'd0, out_valid}, 64'd1);
        tick();
        check_eq("mix", {32'd0, product}, 64'h12350000);
        tick();

        // Eight back-to-back inputs, one product per cycle
        for (int i = 0; i < 8; i++) begin
            ss[i] = $urandom;
            cs[i] = $urandom;
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, ss[i], cs[i]);
            else drive(1'b0, '0, '0);
            if (i < 8) check_eq("stream_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
            if (i >= 1) begin
                check_eq("stream_valid", {63'd0, out_valid}, 64'd1);
                check_eq("stream_product", {32'd0, product}, {32'd0, ss[i-1] + cs[i-1]});
            end
        end
        tick();

        // Backpressure: A,B fill the pipe, C must wait
        out_ready = 1'b0;
        drive(1'b1, 32'h00000010, 32'h00000001);   // A = 0x11
        tick();
        drive(1'b1, 32'h00000020, 32'h00000002);   // B = 0x22
        tick();
        check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("bp_product_a", {32'd0, product}, 64'h11);
        drive(1'b1, 32'h00000030, 32'h00000003);   // C = 0x33
        tick();
        check_eq("bp_hold_a", {32'd0, product}, 64'h11);
        check_eq("bp_still_blocked", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready_release", {63'd0, in_ready}, 64'd1);
        tick();
        drive(1'b0, '0, '0);
        check_eq("bp_product_b", {32'd0, product}, 64'h22);
        tick();
        check_eq("bp_product_c", {32'd0, product}, 64'h33);
        tick();
        check_eq("bp_empty", {63'd0, out_valid}, 64'd0);

        // Reset with two items in flight
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA0000, 32'h00005555);
        tick();
        drive(1'b1, 32'h01010101, 32'h10101010);
        tick();
        drive(1'b0, '0, '0);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("mid_rst_product", {32'd0, product}, 64'd0);
        check_eq("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("no_stale_output", {63'd0, out_valid}, 64'd0);
        end

        // Randomized handshakes
        begin
            int unsigned cycles = 0;
            int unsigned target = accepted + 10000;
            while (accepted < target && cycles < 60000) begin
                drive(1'($urandom_range(0, 1)), $urandom, $urandom);
                out_ready = 1'($urandom_range(0, 1));
                tick();
                cycles++;
            end
            check_eq("rand_all_accepted", {63'd0, accepted >= target}, 64'd1);
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("rand_drained_queue", 64'(expq.size()), 64'd0);
        check_eq("rand_final_valid", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
